// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Owner index width: max(1, clog2(n)).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Beat counter width: max(1, clog2(m)).
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request strictly after last_owner_i, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_owner_i,
    output logic [IDW-1:0]     pick_o,
    output logic               any_o
);

    localparam int unsigned SW = IDW + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SW-1:0]        start;
    logic [SW-1:0]        sum;
    logic                 found;

    // Rotate the doubled request vector so the search origin lands at bit 0, then take the lowest set bit.
    always_comb begin
        start = SW'(last_owner_i) + SW'(1);
        if (start >= SW'(NUM_REQ)) begin
            start = '0;
        end
        dbl    = {req_i, req_i};
        rot    = NUM_REQ'(dbl >> start);
        any_o  = |req_i;
        pick_o = '0;
        found  = 1'b0;
        sum    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                sum = start + SW'(k);
                if (sum >= SW'(NUM_REQ)) begin
                    sum = sum - SW'(NUM_REQ);
                end
                pick_o = IDW'(sum);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDW       = id_width(NUM_REQ),
    localparam int unsigned CW        = cnt_width(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [IDW-1:0]        last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IDW-1:0]        pick;
    logic                  any_req;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_owner_i (last_q),
        .pick_o       (pick),
        .any_o        (any_req)
    );

    // State, owner, round-robin pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; beats are written to the FIFO in the same cycle they are accepted.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        own_valid    = 1'b0;
        own_data     = '0;
        accept       = 1'b0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDW'(i)) begin
                own_valid = req_valid[i];
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (state_q == BURST) begin
                    req_ready[i] = ~fifo_full;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                accept     = own_valid & ~fifo_full;
                fifo_wr_en = accept;
                if (accept) begin
                    fifo_wr_data = own_data;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!own_valid) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a per-requester expected-write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [IDW-1:0]    grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_mem [NR][64];
    int            src_rd [NR];
    int            src_wr [NR];
    logic [NR-1:0] en;

    int pass_cnt  = 0;
    int total     = 0;
    int fail_cnt  = 0;
    int proto_err = 0;
    int bad_data  = 0;

    logic [255:0]   tr_wr;
    logic [255:0]   tr_busy;
    logic [IDW-1:0] tr_gid [256];
    logic [NR-1:0]  tr_rdy [256];
    int             tr_n;
    int             wr_ids[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int id, input logic [DW-1:0] d);
        exp_t e;
        src_mem[id][src_wr[id]] = d;
        src_wr[id]++;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_trace();
        tr_wr   = '0;
        tr_busy = '0;
        tr_n    = 0;
        wr_ids.delete();
    endtask

    task automatic clear_sources();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = en[i] && (src_rd[i] != src_wr[i]);
            req_data[i*DW +: DW] = req_valid[i] ? src_mem[i][src_rd[i]] : DW'($urandom);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, retire handshakes at posedge.
    task automatic cycle();
        logic [NR-1:0] hs;
        int idx;
        drive();
        #1;
        if (tr_n < 256) begin
            tr_wr[tr_n]   = fifo_wr_en;
            tr_busy[tr_n] = busy;
            tr_gid[tr_n]  = grant_id;
            tr_rdy[tr_n]  = req_ready;
            tr_n++;
        end
        if ($countones(req_ready) > 1) proto_err++;
        hs = req_ready & req_valid;
        if ((|hs) !== fifo_wr_en) proto_err++;
        if (fifo_wr_en === 1'b1) begin
            wr_ids.push_back(int'(grant_id));
            idx = -1;
            foreach (exp_q[k]) if (idx < 0 && exp_q[k].id == int'(grant_id)) idx = k;
            chk("sb_expected_write", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                chk("wr_data", 32'(fifo_wr_data), 32'(exp_q[idx].data));
                exp_q.delete(idx);
            end
        end else if (fifo_wr_data !== '0) begin
            bad_data++;
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (hs[i]) src_rd[i]++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int  n;
        bit  done;
        bit  empty;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            cycle();
            n++;
            empty = 1'b1;
            for (int i = 0; i < NR; i++) if (src_rd[i] != src_wr[i]) empty = 1'b0;
            if (empty && tr_busy[tr_n-1] == 1'b0) done = 1'b1;
        end
        chk({tag, "_drain_done"}, 32'(done), 32'd1);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0]  or_rdy;
        logic [IDW-1:0] or_gid;
        int cnt [NR];
        int worst, mx, mn, seq_err, last_wr, idle_n, busy_n;
        logic [31:0] seq;

        rst       = 1'b0;
        fifo_full = 1'b0;
        en        = '1;
        req_valid = '0;
        req_data  = '0;
        clear_sources();
        clear_trace();
        @(negedge clk);

        // Reset held with every requester valid.
        for (int i = 0; i < NR; i++) load(i, DW'(8'hC0 + i));
        repeat (5) cycle();
        or_rdy = '0;
        or_gid = '0;
        for (int k = 0; k < 5; k++) begin
            or_rdy = or_rdy | tr_rdy[k];
            or_gid = or_gid | tr_gid[k];
        end
        chk("rst_req_ready", 32'(or_rdy), 32'd0);
        chk("rst_wr_en", 32'(tr_wr[4:0]), 32'd0);
        chk("rst_busy", 32'(tr_busy[4:0]), 32'd0);
        chk("rst_grant_id", 32'(or_gid), 32'd0);
        rst = 1'b1;
        clear_trace();
        drain("rst", 60);
        chk("rst_first_grant", 32'(wr_ids[0]), 32'd0);

        // Single requester, 6 beats, burst cap 4.
        clear_trace();
        for (int k = 0; k < 6; k++) load(2, DW'(8'hA0 + k));
        repeat (10) cycle();
        chk("single_wr_pattern", 32'(tr_wr[9:0]), 32'h0DE);
        chk("single_busy_pattern", 32'(tr_busy[9:0]), 32'h1DE);
        chk("single_gid", 32'(tr_gid[1]), 32'd2);
        drain("single", 20);

        // Fairness, all four continuously valid.
        rst_pulse();
        clear_trace();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 12; k++) load(i, DW'(i * 16 + k));
        drain("fair", 120);
        chk("fair_writes", 32'(wr_ids.size()), 32'd48);
        seq_err = 0;
        worst   = 0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        foreach (wr_ids[w]) begin
            if (wr_ids[w] != (w / 4) % 4) seq_err++;
            cnt[wr_ids[w]]++;
            mx = cnt[0];
            mn = cnt[0];
            for (int i = 1; i < NR; i++) begin
                if (cnt[i] > mx) mx = cnt[i];
                if (cnt[i] < mn) mn = cnt[i];
            end
            if (mx - mn > worst) worst = mx - mn;
        end
        chk("fair_seq_errs", 32'(seq_err), 32'd0);
        chk("fair_balance_le4", 32'(worst <= 4), 32'd1);
        last_wr = 0;
        busy_n  = 0;
        for (int k = 0; k < tr_n; k++) begin
            if (tr_wr[k]) last_wr = k;
            if (tr_busy[k]) busy_n++;
        end
        idle_n = 0;
        for (int k = 0; k < last_wr; k++) if (!tr_busy[k]) idle_n++;
        chk("fair_busy_cycles", 32'(busy_n), 32'd48);
        chk("fair_idle_gaps", 32'(idle_n), 32'd12);

        // Backpressure on requester 1 after its second beat.
        clear_trace();
        for (int k = 0; k < 4; k++) load(1, DW'(8'h60 + k));
        for (int k = 0; k < 10; k++) begin
            fifo_full = (k >= 3 && k <= 5);
            cycle();
        end
        fifo_full = 1'b0;
        chk("bp_wr_pattern", 32'(tr_wr[9:0]), 32'h0C6);
        chk("bp_busy_pattern", 32'(tr_busy[9:0]), 32'h0FE);
        or_rdy = '0;
        for (int k = 3; k <= 5; k++) or_rdy = or_rdy | tr_rdy[k];
        chk("bp_ready_low", 32'(or_rdy), 32'd0);
        chk("bp_gid_hold3", 32'(tr_gid[3]), 32'd1);
        chk("bp_gid_hold5", 32'(tr_gid[5]), 32'd1);
        drain("bp", 20);
        chk("bp_writes", 32'(wr_ids.size()), 32'd4);

        // Early release by requester 0 while requester 3 waits.
        rst_pulse();
        clear_trace();
        load(0, 8'h10);
        load(0, 8'h11);
        for (int k = 0; k < 3; k++) load(3, DW'(8'h30 + k));
        repeat (4) cycle();
        load(0, 8'h12);
        drain("early", 40);
        chk("early_release_busy", 32'(tr_busy[3]), 32'd1);
        chk("early_release_nowr", 32'(tr_wr[3]), 32'd0);
        chk("early_idle_after", 32'(tr_busy[4]), 32'd0);
        chk("early_next_gid", 32'(tr_gid[5]), 32'd3);
        seq = '0;
        foreach (wr_ids[w]) if (w < 8) seq = seq | (32'(wr_ids[w]) << (4 * w));
        chk("early_writes", 32'(wr_ids.size()), 32'd6);
        chk("early_grant_seq", seq, 32'h0003_3300);

        // Asynchronous reset while requester 1 presents its second beat.
        clear_trace();
        for (int k = 0; k < 4; k++) load(1, DW'(8'h40 + k));
        load(2, 8'h50);
        load(2, 8'h51);
        repeat (2) cycle();
        drive();
        #1;
        chk("ar_pre_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("ar_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_wr_en_drop", 32'(fifo_wr_en), 32'd0);
        chk("ar_busy_drop", 32'(busy), 32'd0);
        chk("ar_ready_drop", 32'(req_ready), 32'd0);
        chk("ar_gid_zero", 32'(grant_id), 32'd0);
        clear_sources();
        @(negedge clk);
        repeat (2) cycle();
        rst = 1'b1;
        clear_trace();
        load(1, 8'h70);
        load(1, 8'h71);
        load(2, 8'h80);
        load(2, 8'h81);
        drain("ar", 30);
        chk("ar_first_grant", 32'(wr_ids[0]), 32'd1);

        chk("protocol_errors", 32'(proto_err), 32'd0);
        chk("idle_data_nonzero", 32'(bad_data), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in front of the async_fifo write side. Runs entirely in the FIFO write clock domain.
- Shares one FIFO write port among NUM_REQ requesters using valid/ready handshakes.
- Grants bursts of up to MAX_BURST beats per owner.
- Drives the FIFO's wr_en/wr_data and obeys its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, FIFO data width; must match the FIFO instance.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1).

Ports:
- clk  input  1  write-domain clock; same net as the FIFO wr_clk.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed requester data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- grant_id  output  IDW  current or last owner index; IDW = max(1, $clog2(NUM_REQ)).
- busy  output  1  high while in BURST.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, beat_cnt=0.
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0.
- State machine has two states, IDLE and BURST.
- IDLE:
  - If any req_valid, pick the first set bit searching from last_owner+1 upward, with wrap-around modulo NUM_REQ.
  - On the next edge: owner<=pick, beat_cnt<=0, state<=BURST.
  - No accept in IDLE. Each grant therefore costs exactly 1 arbitration cycle.
- BURST:
  - accept = req_valid[owner] & ~fifo_full, combinational.
  - req_ready[owner] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = accept.
  - fifo_wr_data = req_data[owner] when accept, else 0.
  - The beat is written in the same cycle; zero latency from handshake to FIFO write.
- Transitions out of BURST, in priority order:
  - accept and beat_cnt==MAX_BURST-1: state<=IDLE, last_owner<=owner.
  - accept otherwise: beat_cnt<=beat_cnt+1.
  - ~req_valid[owner]: release. state<=IDLE, last_owner<=owner, and nothing is written that cycle.
  - req_valid[owner] & fifo_full: hold. Owner and beat_cnt unchanged, fifo_wr_en=0.
- grant_id: equals owner in BURST and holds its value in IDLE. busy = (state==BURST).
- Widths: beat_cnt is max(1, $clog2(MAX_BURST)) bits and never exceeds MAX_BURST-1. The round-robin index wraps NUM_REQ-1 -> 0.
- MAX_BURST=1: every accepted beat returns to IDLE. Throughput is one beat per 2 cycles.
- Non-owner req_valid changes during BURST have no effect.
- Requesters must hold req_data stable while req_valid=1 and ready=0.
- Never writes while fifo_full=1. Overflow is impossible by construction.
- Reset mid-burst: outputs drop immediately (asynchronously). After reset release, requester 0 has top priority.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - width helper functions for IDW and the beat_cnt width.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, last_owner.
  - Outputs: pick index, any flag.
  - Implementation: double-width rotate-and-mask. Purely combinational.

Test Plan:
- Reset: hold rst=0 for 5 cycles with all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0, grant_id=0. First grant after release is requester 0.
- Single requester: only req 2 valid with 6 beats (0xA0..0xA5), MAX_BURST=4, fifo_full=0:
  - 1 IDLE cycle, then fifo_wr_en=1 for 4 cycles writing A0..A3.
  - 1 IDLE cycle, then 2 cycles writing A4..A5.
  - Release, busy=0.
- Fairness: all 4 requesters continuously valid, 12 beats each -> grant_id sequence 0,1,2,3,0,1,2,3,...
  - Each grant is exactly 4 beats with one idle cycle between grants.
  - Beat counts per requester equal within ±4 at any point.
- Backpressure: fifo_full=1 for 3 cycles after the 2nd beat of req 1's burst:
  - req_ready=0 and fifo_wr_en=0 for those 3 cycles; grant_id stays 1.
  - Beats 3 and 4 follow when full drops.
  - Total writes equal offered beats; nothing is lost or duplicated.
- Early release: req 0 drops valid after 2 beats while req 3 is valid -> arbiter returns to IDLE, next grant_id=3 (req 1 and req 2 idle). Req 0 is not re-granted before req 3.
- Async reset mid-burst: assert rst=0 between clock edges during beat 2 of req 1 -> fifo_wr_en and busy fall without a clock edge. After release with req 1 and req 2 valid, the first grant is req 1 (search from index 0 upward).
